// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch predictor.
interface branch_predictor_if;
    logic [31:0] PC_IF;
    logic        pred_taken_IF;
    logic [31:0] pred_target_IF;
    logic        stall;
    logic        flush;
    logic [31:0] PC_EX;
    logic        is_branch_EX;
    logic        taken_EX;
    logic [31:0] target_EX;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    // Pipeline front end drives fetch/resolve info and consumes predictions.
    modport master (
        output PC_IF, stall, flush, PC_EX, is_branch_EX, taken_EX, target_EX,
        input  pred_taken_IF, pred_target_IF, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  PC_IF, stall, flush, PC_EX, is_branch_EX, taken_EX, target_EX,
        output pred_taken_IF, pred_target_IF, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB with 2-bit counters. Predicts at IF, carries the
// prediction through ID/EX registers, and checks/updates it at EX.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic        vld;
        logic        taken;
        logic [31:0] tgt;
    } pstage_t;

    // Table state, one slot per entry.
    logic [ENTRIES-1:0]            r_vld;
    logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
    logic [ENTRIES-1:0][31:0]      r_tgt;
    logic [ENTRIES-1:0][1:0]       r_ctr;

    pstage_t     r_id;
    pstage_t     r_ex;
    logic [31:0] r_br_cnt;
    logic [31:0] r_mp_cnt;

    // Fetch-side lookup (reads pre-update contents, no bypass).
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_if_taken;
    logic [31:0]      w_if_pc4;
    logic [31:0]      w_if_tgt;

    assign w_if_idx   = bp.PC_IF[IDX_W+1:2];
    assign w_if_tag   = bp.PC_IF[31:IDX_W+2];
    assign w_if_hit   = r_vld[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_taken = w_if_hit && r_ctr[w_if_idx][1];
    assign w_if_pc4   = bp.PC_IF + 32'd4;
    assign w_if_tgt   = w_if_taken ? r_tgt[w_if_idx] : w_if_pc4;

    assign bp.pred_taken_IF  = w_if_taken;
    assign bp.pred_target_IF = w_if_tgt;

    // EX-side resolution.
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_ex_br;
    logic [31:0]      w_ex_pc4;
    logic             w_mp;
    logic [1:0]       w_ctr_nxt;

    assign w_ex_idx = bp.PC_EX[IDX_W+1:2];
    assign w_ex_tag = bp.PC_EX[31:IDX_W+2];
    assign w_ex_hit = r_vld[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_br  = r_ex.vld && bp.is_branch_EX;
    assign w_ex_pc4 = bp.PC_EX + 32'd4;

    // Mispredict: wrong direction, wrong taken target, or a taken guess on a non-branch.
    always_comb begin
        w_mp = 1'b0;
        if (rst_n && r_ex.vld) begin
            if (bp.is_branch_EX)
                w_mp = (r_ex.taken != bp.taken_EX) ||
                       (r_ex.taken && bp.taken_EX && (r_ex.tgt != bp.target_EX));
            else
                w_mp = r_ex.taken;
        end
    end

    // Saturating 2-bit counter step for the resolved branch.
    always_comb begin
        w_ctr_nxt = r_ctr[w_ex_idx];
        if (bp.taken_EX) begin
            if (r_ctr[w_ex_idx] != 2'b11) w_ctr_nxt = r_ctr[w_ex_idx] + 2'd1;
        end else begin
            if (r_ctr[w_ex_idx] != 2'b00) w_ctr_nxt = r_ctr[w_ex_idx] - 2'd1;
        end
    end

    assign bp.mispredict       = w_mp;
    assign bp.redirect_pc      = (bp.is_branch_EX && bp.taken_EX) ? bp.target_EX : w_ex_pc4;
    assign bp.branch_count     = r_br_cnt;
    assign bp.mispredict_count = r_mp_cnt;

    // ID/EX prediction registers: kill beats stall, stall holds ID and bubbles EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id <= '0;
            r_ex <= '0;
        end else if (bp.flush || w_mp) begin
            r_id <= '0;
            r_ex <= '0;
        end else if (bp.stall) begin
            r_ex <= '0;
        end else begin
            r_id <= '{vld: 1'b1, taken: w_if_taken, tgt: w_if_tgt};
            r_ex <= r_id;
        end
    end

    // Table training on resolved branches; a miss only allocates when taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_vld[i] <= 1'b0;
                r_tag[i] <= '0;
                r_tgt[i] <= '0;
                r_ctr[i] <= 2'b01;
            end
        end else if (w_ex_br) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_nxt;
                if (bp.taken_EX) r_tgt[w_ex_idx] <= bp.target_EX;
            end else if (bp.taken_EX) begin
                r_vld[w_ex_idx] <= 1'b1;
                r_tag[w_ex_idx] <= w_ex_tag;
                r_tgt[w_ex_idx] <= bp.target_EX;
                r_ctr[w_ex_idx] <= 2'b10;
            end
        end
    end

    // Statistics counters, free-running with natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else begin
            if (w_ex_br) r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mp)    r_mp_cnt <= r_mp_cnt + 32'd1;
        end
    end
endmodule
